// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM burst stream reader.
//   - supported RAM read latencies (low-latency vs high-performance RAM)
//   - FSM state encoding
//   - tag carried alongside each RAM read through the read pipeline
//   - clog2 for address/pointer sizing
package bram_stream_reader_pkg;

  localparam int RD_LAT_LOW  = 1;
  localparam int RD_LAT_HIGH = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Rides next to a RAM read: marks the RAM output as a real word and
  // flags the final word of the burst.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // Never returns 0 so a depth-1 memory still gets a legal 1-bit address.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// sync_stream_fifo: single-clock FIFO buffering RAM words for the stream.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push/pushData : write one entry; legal when full only together with pop
//   pop/popData   : popData shows the head entry; pop removes it
//   full, empty   : occupancy flags
module sync_stream_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic [W-1:0] popData,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
    $error("sync_stream_fifo: DEPTH must be a power of two >= 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign popData = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two. When full,
  // a push lands in the slot being popped this same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: burst read controller for one port of a no-change BRAM.
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : burst command (len 0 = no-op)
//   ram_addr/ram_rden/ram_dout           : RAM read port; rden also clocks
//                                          the RAM output register chain
//   m_valid/m_ready/m_data/m_last        : output word stream
//   busy                                 : burst in flight or words buffered
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int C_RAM_WIDTH  = 32,
  parameter int C_RAM_DEPTH  = 1024,
  parameter int C_RD_LATENCY = 1,
  parameter int C_FIFO_DEPTH = 4,
  parameter int C_LEN_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [clog2(C_RAM_DEPTH)-1:0]   cmd_addr,
  input  logic [C_LEN_WIDTH-1:0]          cmd_len,
  output logic [clog2(C_RAM_DEPTH)-1:0]   ram_addr,
  output logic                            ram_rden,
  input  logic [C_RAM_WIDTH-1:0]          ram_dout,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [C_RAM_WIDTH-1:0]          m_data,
  output logic                            m_last,
  output logic                            busy
);

  localparam int AW = clog2(C_RAM_DEPTH);
  localparam int L  = C_RD_LATENCY;

  if (L != RD_LAT_LOW && L != RD_LAT_HIGH) begin : gBadLatency
    $error("bram_stream_reader: C_RD_LATENCY must be 1 or 3");
  end

  logic [1:0]             state;
  logic [AW-1:0]          addr, lastAddr;
  logic [C_LEN_WIDTH-1:0] remaining;
  tag_t                   vpipe [L];

  logic                   fifoFull, fifoEmpty, push, pop;
  logic                   issue, lastIssue;
  logic                   anyValid, lowerValid, pipeEmptyNext;
  logic [C_RAM_WIDTH:0]   fifoOut;

  assign pop     = !fifoEmpty && m_ready;
  assign m_valid = !fifoEmpty;
  assign m_data  = fifoOut[C_RAM_WIDTH:1];
  assign m_last  = !fifoEmpty && fifoOut[0];

  // Advancing the RAM chain is only unsafe when its output holds a real
  // word that the FIFO cannot take this cycle.
  assign ram_rden  = (state != ST_IDLE) &&
                     (!vpipe[L-1].valid || !fifoFull || pop);
  assign issue     = (state == ST_ISSUE) && ram_rden;
  assign lastIssue = issue && (remaining == C_LEN_WIDTH'(1));
  assign push      = ram_rden && vpipe[L-1].valid;

  // Hold the last issued address outside ISSUE so drain reads are inert.
  assign ram_addr  = (state == ST_ISSUE) ? addr : lastAddr;
  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE) || anyValid || !fifoEmpty;

  // Tag pipeline is empty after this edge if nothing remains, or if the
  // only valid tag is in the last stage and it shifts out now.
  always_comb begin
    anyValid   = 1'b0;
    lowerValid = 1'b0;
    for (int i = 0; i < L; i++)     anyValid   |= vpipe[i].valid;
    for (int i = 0; i < L - 1; i++) lowerValid |= vpipe[i].valid;
    pipeEmptyNext = ram_rden ? !(lowerValid || issue) : !anyValid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) vpipe[i] <= '0;
    end else if (ram_rden) begin
      vpipe[0] <= '{valid: issue, last: lastIssue};
      for (int i = 1; i < L; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      lastAddr  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_len != '0) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            lastAddr  <= addr;
            addr      <= (addr == AW'(C_RAM_DEPTH - 1)) ? '0 : addr + AW'(1);
            remaining <= remaining - C_LEN_WIDTH'(1);
            if (lastIssue) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipeEmptyNext) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_stream_fifo #(
    .W     (C_RAM_WIDTH + 1),
    .DEPTH (C_FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData ({ram_dout, vpipe[L-1].last}),
    .pop      (pop),
    .popData  (fifoOut),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Two readers share clk/rst: instance 0 drives a low-latency RAM model (1
// stage), instance 1 a high-performance one (3 stages). RAM content is
// mem[a] = a, so returned data also proves the issued address order.
module tb_bram_stream_reader;

  logic        clk, rst;
  logic        cmdValid [2];
  logic        cmdReady [2];
  logic [9:0]  cmdAddr  [2];
  logic [15:0] cmdLen   [2];
  logic [9:0]  ramAddr  [2];
  logic        ramRden  [2];
  logic [31:0] ramDout  [2];
  logic        mValid   [2];
  logic        mReady   [2];
  logic [31:0] mData    [2];
  logic        mLast    [2];
  logic        busy     [2];

  int nCmp = 0;
  int nErr = 0;
  int cyc  = 0;

  // scoreboard and reference model state, per instance
  logic [32:0] q [2][$];
  int          readyMode [2];
  int          issuesLeft[2];
  logic [9:0]  nextAddr  [2];
  logic [2:0]  tv        [2];
  logic        prevStall [2];
  logic [32:0] prevWord  [2];
  logic        latArm    [2];
  int          accEdge   [2];
  logic        accMv;

  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] pipe [3];

    bram_stream_reader #(
      .C_RAM_WIDTH(32), .C_RAM_DEPTH(1024), .C_RD_LATENCY(L),
      .C_FIFO_DEPTH(4), .C_LEN_WIDTH(16)
    ) uDut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmdValid[g]), .cmd_ready(cmdReady[g]),
      .cmd_addr(cmdAddr[g]), .cmd_len(cmdLen[g]),
      .ram_addr(ramAddr[g]), .ram_rden(ramRden[g]), .ram_dout(ramDout[g]),
      .m_valid(mValid[g]), .m_ready(mReady[g]), .m_data(mData[g]),
      .m_last(mLast[g]), .busy(busy[g])
    );

    // rden-gated RAM output chain
    always @(posedge clk) begin
      if (ramRden[g]) begin
        pipe[0] <= {22'h0, ramAddr[g]};
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
      end
    end
    assign ramDout[g] = pipe[L-1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int lat(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called and returns at posedge+1 so consecutive calls keep cmd_valid high.
  task automatic sendCmd(input int s, input logic [9:0] a, input logic [15:0] n);
    int t;
    t = 0;
    cmdValid[s] = 1'b1; cmdAddr[s] = a; cmdLen[s] = n;
    @(negedge clk);
    while (!cmdReady[s] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_accept", (t < 200), 1);
    accMv = mValid[s];
    if (n != 0 && q[s].size() == 0) begin
      latArm[s]  = 1'b1;
      accEdge[s] = cyc + 1;
    end
    for (int i = 0; i < int'(n); i++)
      q[s].push_back({(i == int'(n) - 1), 32'((int'(a) + i) % 1024)});
    @(posedge clk); #1;
    cmdValid[s] = 1'b0;
  endtask

  task automatic waitDrain(input int s);
    int t;
    t = 0;
    while (q[s].size() != 0 && t < 1000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("drain_in_time", (t < 1000), 1);
    @(negedge clk); #1;
    chk("busy_after_drain", busy[s], 0);
    chk("valid_after_drain", mValid[s], 0);
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++)
      mReady[s] = (readyMode[s] == 0) ? 1'b1 :
                  (readyMode[s] == 1) ? (cyc % 3 == 0) : 1'b0;
  end

  // Reference model and scoreboard, evaluated just before each posedge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        automatic int   L      = lat(s);
        automatic logic active = (issuesLeft[s] != 0) || (tv[s] != 3'b000);
        automatic logic issueNow;
        chk("cmd_ready", cmdReady[s], !active);
        chk("busy", busy[s], active || mValid[s]);
        if (!active) chk("rden_idle", ramRden[s], 0);
        else if (!tv[s][L-1] || !(mValid[s] && !mReady[s]))
          chk("rden_stall", ramRden[s], 1);
        issueNow = ramRden[s] && issuesLeft[s] != 0;
        if (issueNow) begin
          chk("ram_addr", ramAddr[s], nextAddr[s]);
          nextAddr[s]   = nextAddr[s] + 10'd1;
          issuesLeft[s] = issuesLeft[s] - 1;
        end
        if (ramRden[s])
          tv[s] = {tv[s][1:0], issueNow} & ((L == 1) ? 3'b001 : 3'b111);
        if (cmdValid[s] && cmdReady[s]) begin
          issuesLeft[s] = int'(cmdLen[s]);
          nextAddr[s]   = cmdAddr[s];
        end
        if (prevStall[s])
          chk("stall_hold", {mValid[s], mLast[s], mData[s]}, {1'b1, prevWord[s]});
        prevStall[s] = mValid[s] && !mReady[s];
        prevWord[s]  = {mLast[s], mData[s]};
        if (latArm[s] && mValid[s]) begin
          chk("first_latency", cyc - accEdge[s], 1 + L);
          latArm[s] = 1'b0;
        end
        if (mValid[s] && mReady[s]) begin
          if (q[s].size() == 0) chk("extra_word", {mLast[s], mData[s]}, 33'h1_FFFF_FFFF);
          else chk("word", {mLast[s], mData[s]}, q[s].pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      cmdValid[s] = 0; cmdAddr[s] = '0; cmdLen[s] = '0; mReady[s] = 1'b1;
      readyMode[s] = 0; issuesLeft[s] = 0; nextAddr[s] = '0; tv[s] = '0;
      prevStall[s] = 0; prevWord[s] = '0; latArm[s] = 0; accEdge[s] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_cmd_ready", cmdReady[s], 0);
      chk("rst_rden", ramRden[s], 0);
      chk("rst_ram_addr", ramAddr[s], 0);
      chk("rst_m_valid", mValid[s], 0);
      chk("rst_m_last", mLast[s], 0);
      chk("rst_busy", busy[s], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("idle_cmd_ready0", cmdReady[0], 1);
    chk("idle_cmd_ready1", cmdReady[1], 1);
    step(1);

    // 1: L=1 basic burst, latency and last flag
    sendCmd(0, 10'h010, 16'd4);
    waitDrain(0);

    // 2: L=3 burst wrapping from the top of the address space
    sendCmd(1, 10'h3FE, 16'd4);
    waitDrain(1);

    // 3: L=3 long burst under 1-in-3 ready plus a 20-cycle stall
    readyMode[1] = 1;
    sendCmd(1, 10'h200, 16'd16);
    step(8);
    readyMode[1] = 2;
    step(20);
    readyMode[1] = 1;
    waitDrain(1);
    readyMode[1] = 0;
    step(2);

    // 4: zero-length no-op, then a single word
    sendCmd(0, 10'd5, 16'd0);
    step(6);
    chk("len0_busy", busy[0], 0);
    chk("len0_valid", mValid[0], 0);
    sendCmd(0, 10'd5, 16'd1);
    waitDrain(0);

    // 5: back-to-back bursts, second offered continuously
    sendCmd(1, 10'd0, 16'd3);
    sendCmd(1, 10'd100, 16'd2);
    chk("b2b_fifo_nonempty", accMv, 1);
    waitDrain(1);

    // 6: reset after 2 of 8 words abandons the burst
    sendCmd(1, 10'h080, 16'd8);
    begin
      int t;
      t = 0;
      while (q[1].size() > 6 && t < 300) begin
        @(negedge clk); #1;
        t++;
      end
      chk("mid_burst_reached", (t < 300), 1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      q[s].delete();
      issuesLeft[s] = 0; tv[s] = '0; prevStall[s] = 0; latArm[s] = 0;
    end
    @(negedge clk); #1;
    chk("post_rst_valid", mValid[1], 0);
    chk("post_rst_rden", ramRden[1], 0);
    chk("post_rst_cmd_ready", cmdReady[1], 1);
    chk("post_rst_busy", busy[1], 0);
    @(posedge clk); #1;
    sendCmd(1, 10'h040, 16'd2);
    waitDrain(1);
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
